pixel_stream_convert: RTL and testbench

PIXEL_STREAM_CONVERT -- requirements
Module: pixel_stream_convert

---
 rtl/pixel_stream_convert.sv | 90 +++++++++
 tb/tb_pixel_stream_convert.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_stream_convert.sv
// Converts a stream of binary pixels into fixed-point values (0 or 1.0) with
// a frame-latched polarity, buffered through a small ready/valid output FIFO.
module pixel_stream_convert #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 10,
  parameter int DEPTH  = 4,
  parameter int NPIX   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              invert,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        frame_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(NPIX);
  localparam logic [DWIDTH-1:0] ONE_VAL  = DWIDTH'(1) << FRAC;
  localparam logic [IW-1:0]     LAST_IDX = IW'(NPIX - 1);

  logic [DWIDTH:0] mem [DEPTH];
  logic [PW:0]     wr_ptr;
  logic [PW:0]     rd_ptr;
  logic [IW-1:0]   pix_idx;
  logic            frame_inv;
  logic [7:0]      frame_cnt_q;

  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            cur_inv;
  logic            eff;
  logic [DWIDTH:0] push_entry;
  logic [DWIDTH:0] head;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign push  = in_valid && !full;
  assign pop   = !empty && out_ready;

  // Pixel 0 uses the live invert input; later pixels use the value latched with it.
  assign cur_inv    = (pix_idx == '0) ? invert : frame_inv;
  assign eff        = in_bit ^ cur_inv;
  assign push_entry = {(pix_idx == LAST_IDX), (eff ? ONE_VAL : '0)};

  assign head      = mem[rd_ptr[PW-1:0]];
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : head[DWIDTH-1:0];
  assign out_last  = !empty && head[DWIDTH];
  assign frame_cnt = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[PW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pix_idx     <= '0;
      frame_inv   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= wr_ptr + 1'b1;
        pix_idx <= (pix_idx == LAST_IDX) ? '0 : pix_idx + 1'b1;
        if (pix_idx == '0) begin
          frame_inv <= invert;
        end
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        if (head[DWIDTH]) begin
          frame_cnt_q <= frame_cnt_q + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_convert.sv
// Directed self-checking bench for pixel_stream_convert at default parameters.
module tb_pixel_stream_convert;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_bit;
  logic        invert;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [7:0]  frame_cnt;

  int errors = 0;
  int checks = 0;

  pixel_stream_convert #(.DWIDTH(16), .FRAC(10), .DEPTH(4), .NPIX(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .invert    (invert),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic b, input logic inv, input logic rdy);
    in_valid  = v;
    in_bit    = b;
    invert    = inv;
    out_ready = rdy;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] bp_pat;
    rst = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    do_reset();
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_out_data", out_data, 0);
    check_output("rst_out_last", out_last, 0);
    check_output("rst_frame_cnt", frame_cnt, 0);

    // Single pixel conversion and one-cycle latency
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_output("single_valid", out_valid, 1);
    check_output("single_data", out_data, 32'h0400);
    check_output("single_last", out_last, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_output("hold_data", out_data, 32'h0400);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("second_valid", out_valid, 1);
    check_output("second_data", out_data, 32'h0000);
    tick();
    check_output("drained_valid", out_valid, 0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("pop_empty_valid", out_valid, 0);
    check_output("pop_empty_ready", in_ready, 1);

    // Backpressure: five pushes into a four-entry FIFO
    do_reset();
    bp_pat = 5'b01101;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, bp_pat[i], 1'b0, 1'b0);
      check_output($sformatf("bp_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
      tick();
    end
    check_output("bp_full_ready", in_ready, 0);
    check_output("bp_head0", out_data, 32'h0400);
    apply_stimulus(1'b1, bp_pat[4], 1'b0, 1'b1);
    tick();
    check_output("bp_ready_after_pop", in_ready, 1);
    check_output("bp_head1", out_data, 32'h0000);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    check_output("bp_head2", out_data, 32'h0400);
    tick();
    check_output("bp_head3", out_data, 32'h0400);
    tick();
    check_output("bp_head4_valid", out_valid, 1);
    check_output("bp_head4", out_data, 32'h0000);
    tick();
    check_output("bp_empty", out_valid, 0);

    // Frame boundary and out_last placement
    do_reset();
    for (int k = 0; k < 65; k++) begin
      apply_stimulus(1'b1, k[0], 1'b0, 1'b1);
      tick();
      check_output($sformatf("frm_valid_%0d", k), out_valid, 1);
      check_output($sformatf("frm_data_%0d", k), out_data, k[0] ? 32'h0400 : 32'h0);
      check_output($sformatf("frm_last_%0d", k), out_last, (k == 63) ? 1 : 0);
      check_output($sformatf("frm_cnt_%0d", k), frame_cnt, (k == 64) ? 1 : 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("frm_drained", out_valid, 0);

    // Polarity latched at pixel 0 ignores mid-frame invert changes
    do_reset();
    for (int k = 0; k < 64; k++) begin
      apply_stimulus(1'b1, 1'b1, (k < 10) ? 1'b1 : 1'b0, 1'b1);
      tick();
      check_output($sformatf("inv1_data_%0d", k), out_data, 32'h0);
    end
    for (int k = 0; k < 64; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      check_output($sformatf("inv0_data_%0d", k), out_data, 32'h0400);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("inv_frame_cnt", frame_cnt, 2);

    // Reset in the middle of a frame with undrained entries
    do_reset();
    for (int k = 0; k < 28; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    check_output("mid_valid_before", out_valid, 1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_cnt", frame_cnt, 0);
    check_output("mid_rst_ready", in_ready, 1);
    check_output("mid_rst_data", out_data, 0);
    for (int k = 0; k < 64; k++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      check_output($sformatf("mid_last_%0d", k), out_last, (k == 63) ? 1 : 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("mid_frame_cnt", frame_cnt, 1);

    // 256 frames wrap the frame counter back to zero
    do_reset();
    for (int n = 1; n <= 256 * 64; n++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      if (n % 64 == 1) begin
        check_output($sformatf("wrap_cnt_%0d", n), frame_cnt, ((n - 1) / 64) & 255);
      end
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    check_output("wrap_final_cnt", frame_cnt, 0);
    check_output("wrap_final_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
